dcache_ctrl: RTL and testbench

//  Direct-mapped, write-back, write-allocate data cache between the CPU data port and memblock.
//  The CPU issues 64-bit word accesses. Misses refill whole 256-bit blocks via memblock's

---
 rtl/dcache_ctrl_if.sv | 34 +++
 rtl/dcache_ctrl.sv | 125 ++++++++++++
 tb/tb_dcache_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_ctrl_if.sv
// CPU data port and memblock block port of the data cache, bundled as one interface.
// Handshake: a CPU request (cpu_read/cpu_write) completes on the first posedge where cpu_stall=0.
// Toward memblock, blockread is raised only while ready=1. Memblock accepts on its negedge and
// drops ready until readblock is valid. blockwrite is a one-cycle strobe that needs no response.
interface dcache_ctrl_if #(
    parameter int N = 64
);
    logic           cpu_read;
    logic           cpu_write;
    logic [31:0]    cpu_addr;
    logic [N-1:0]   cpu_wdata;
    logic [N-1:0]   cpu_rdata;
    logic           cpu_stall;
    logic           blockread;
    logic           blockwrite;
    logic [31:0]    blockaddr;
    logic [4*N-1:0] writeblock;
    logic [4*N-1:0] readblock;
    logic           ready;
    logic [31:0]    hit_count;
    logic [31:0]    miss_count;

    modport slave (
        input  cpu_read, cpu_write, cpu_addr, cpu_wdata, readblock, ready,
        output cpu_rdata, cpu_stall, blockread, blockwrite, blockaddr, writeblock,
               hit_count, miss_count
    );

    modport master (
        output cpu_read, cpu_write, cpu_addr, cpu_wdata, readblock, ready,
        input  cpu_rdata, cpu_stall, blockread, blockwrite, blockaddr, writeblock,
               hit_count, miss_count
    );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache. Dirty victims are written back
// and whole blocks are refilled through memblock. Hit and miss counters are kept.
module dcache_ctrl #(
    parameter int N     = 64,
    parameter int LINES = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    dcache_ctrl_if.slave bus,
    output logic [1:0]   state_dbg
);
    localparam int IDX = $clog2(LINES);
    localparam int TW  = 27 - IDX;
    localparam int BW  = 4 * N;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WB   = 2'd1;
    localparam logic [1:0] S_REQ  = 2'd2;
    localparam logic [1:0] S_WAIT = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [BW-1:0]    data_q [LINES];
    logic [TW-1:0]    tag_q  [LINES];
    logic [LINES-1:0] valid_q, dirty_q;
    logic [26:0]      mblk_q;
    logic             issued_q, retry_q;
    logic [31:0]      hit_q, miss_q;
    logic [IDX-1:0]   idx, midx;
    logic [TW-1:0]    tag;
    logic [1:0]       word;
    logic             req, hit, lookup, miss, wr_hit, fill;
    logic [2:0]       unused_addr_bits;

    // Word 0 sits in the most significant 64 bits of a block.
    function automatic logic [N-1:0] get_word(input logic [BW-1:0] blk, input logic [1:0] w);
        case (w)
            2'd0:    get_word = blk[4*N-1 -: N];
            2'd1:    get_word = blk[3*N-1 -: N];
            2'd2:    get_word = blk[2*N-1 -: N];
            default: get_word = blk[N-1 -: N];
        endcase
    endfunction

    function automatic logic [BW-1:0] put_word(input logic [BW-1:0] blk, input logic [1:0] w,
                                               input logic [N-1:0] val);
        put_word = blk;
        case (w)
            2'd0:    put_word[4*N-1 -: N] = val;
            2'd1:    put_word[3*N-1 -: N] = val;
            2'd2:    put_word[2*N-1 -: N] = val;
            default: put_word[N-1 -: N]   = val;
        endcase
    endfunction

    assign idx              = bus.cpu_addr[5 +: IDX];
    assign tag              = bus.cpu_addr[31 -: TW];
    assign word             = bus.cpu_addr[4:3];
    assign unused_addr_bits = bus.cpu_addr[2:0];
    assign midx             = mblk_q[IDX-1:0];

    assign req    = bus.cpu_read | bus.cpu_write;
    assign hit    = valid_q[idx] && (tag_q[idx] == tag);
    assign lookup = (state_q == S_IDLE) && req;
    assign miss   = lookup && !hit;
    assign wr_hit = lookup && hit && bus.cpu_write;
    assign fill   = (state_q == S_WAIT) && bus.ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (miss) state_d = (valid_q[idx] && dirty_q[idx]) ? S_WB : S_REQ;
            S_WB:    state_d = S_REQ;
            // Leave REQ only once our own request was seen, not a read pending from before reset.
            S_REQ:   if (!bus.ready && issued_q) state_d = S_WAIT;
            default: if (bus.ready) state_d = S_IDLE;
        endcase
    end

    assign bus.cpu_rdata  = get_word(data_q[idx], word);
    assign bus.cpu_stall  = (state_q != S_IDLE) || miss;
    assign bus.blockwrite = (state_q == S_WB);
    assign bus.blockread  = (state_q == S_REQ) && bus.ready;
    assign bus.blockaddr  = (state_q == S_WB) ? {5'b0, tag_q[midx], midx} : {5'b0, mblk_q};
    assign bus.writeblock = data_q[midx];
    assign bus.hit_count  = hit_q;
    assign bus.miss_count = miss_q;
    assign state_dbg      = state_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            valid_q  <= '0;
            dirty_q  <= '0;
            mblk_q   <= '0;
            issued_q <= 1'b0;
            retry_q  <= 1'b0;
            hit_q    <= '0;
            miss_q   <= '0;
        end else begin
            state_q <= state_d;
            retry_q <= fill;
            // blockread is live during the coming half cycle exactly when ready is high now.
            if (state_d == S_REQ) issued_q <= bus.ready;
            if (miss) begin
                mblk_q <= bus.cpu_addr[31:5];
                miss_q <= miss_q + 32'd1;
            end
            if (lookup && hit && !retry_q) hit_q <= hit_q + 32'd1;
            if (wr_hit) dirty_q[idx] <= 1'b1;
            if (fill) begin
                valid_q[midx] <= 1'b1;
                dirty_q[midx] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fill) begin
            data_q[midx] <= bus.readblock;
            tag_q[midx]  <= mblk_q[26 -: TW];
        end else if (wr_hit) begin
            data_q[idx] <= put_word(data_q[idx], word, bus.cpu_wdata);
        end
    end
endmodule

// File: tb/tb_dcache_ctrl.sv
// Randomized bench for dcache_ctrl: a memblock model on negedge, and a CPU-visible memory
// reference feeding expected read data, write-backs, refill addresses and counters.
module tb_dcache_ctrl;
    localparam int N = 64;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] state_dbg;
    logic       mb_ready = 1'b1;
    logic [255:0] mb_rdata = '0;

    dcache_ctrl_if #(.N(N)) bus();

    dcache_ctrl #(.N(N), .LINES(8)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus), .state_dbg(state_dbg)
    );

    assign bus.ready     = mb_ready;
    assign bus.readblock = mb_rdata;

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // scoreboard queues
    logic [63:0]  exp_q[$];
    logic [31:0]  rdaddr_q[$];
    logic [31:0]  wbaddr_q[$];
    logic [255:0] wbdata_q[$];

    // reference model: CPU-visible memory plus which block each line holds
    logic [63:0]  cpu_mem [logic [28:0]];
    logic [255:0] ref_blk [logic [26:0]];
    bit           m_valid [8];
    bit           m_dirty [8];
    logic [23:0]  m_tag [8];
    int unsigned  hit_exp = 0;
    int unsigned  miss_exp = 0;

    // memblock model storage
    logic [255:0] mem [logic [26:0]];
    int           mb_cnt = 0;
    logic [26:0]  mb_addr = '0;

    logic [23:0]  tags [4];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", name, act, expv);
        end
    endtask

    function automatic logic [63:0] init_word(input logic [28:0] wa);
        return {3'b0, wa, 32'hC0DE_0000 ^ {3'b0, ~wa}};
    endfunction

    function automatic logic [255:0] init_blk(input logic [26:0] b);
        logic [255:0] r;
        for (int w = 0; w < 4; w++) r[255-64*w -: 64] = init_word({b, 2'(w)});
        return r;
    endfunction

    function automatic logic [63:0] ref_word(input logic [28:0] wa);
        logic [255:0] blk;
        if (cpu_mem.exists(wa)) return cpu_mem[wa];
        if (ref_blk.exists(wa[28:2])) begin
            blk = ref_blk[wa[28:2]];
            return blk[255-64*int'(wa[1:0]) -: 64];
        end
        return init_word(wa);
    endfunction

    function automatic logic [255:0] ref_line(input logic [26:0] b);
        logic [255:0] r;
        for (int w = 0; w < 4; w++) r[255-64*w -: 64] = ref_word({b, 2'(w)});
        return r;
    endfunction

    function automatic bit model_hit(input logic [31:0] addr);
        return m_valid[addr[7:5]] && (m_tag[addr[7:5]] == addr[31:8]);
    endfunction

    task automatic model_access(input bit rd, input bit wr, input logic [31:0] addr,
                                input logic [63:0] data);
        logic [2:0]   ix;
        logic [26:0]  vb;
        logic [255:0] line;
        ix = addr[7:5];
        if (model_hit(addr)) begin
            hit_exp++;
        end else begin
            miss_exp++;
            if (m_valid[ix] && m_dirty[ix]) begin
                vb = {m_tag[ix], ix};
                line = ref_line(vb);
                wbaddr_q.push_back({5'b0, vb});
                wbdata_q.push_back(line);
                ref_blk[vb] = line;
            end
            rdaddr_q.push_back({5'b0, addr[31:5]});
            m_valid[ix] = 1'b1;
            m_tag[ix]   = addr[31:8];
            m_dirty[ix] = 1'b0;
        end
        if (wr) begin
            cpu_mem[addr[31:3]] = data;
            m_dirty[ix] = 1'b1;
        end else if (rd) begin
            exp_q.push_back(ref_word(addr[31:3]));
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
        hit_exp = 0;
        miss_exp = 0;
        cpu_mem.delete();
    endtask

    task automatic set_idle();
        bus.cpu_read  = 1'b0;
        bus.cpu_write = 1'b0;
    endtask

    task automatic issue(input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [63:0] data);
        bus.cpu_read  = rd;
        bus.cpu_write = wr;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = data;
    endtask

    // Wait for a negedge with cpu_stall low, then let the completing posedge pass.
    task automatic finish_access(input string name);
        bit done;
        done = 1'b0;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            if (!bus.cpu_stall) done = 1'b1;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL %s_timeout actual=stalled required=complete within 200 cycles", name);
        end
        @(posedge clk);
        #1;
        set_idle();
    endtask

    task automatic access(input bit rd, input bit wr, input logic [31:0] addr,
                          input logic [63:0] data);
        model_access(rd, wr, addr, data);
        issue(rd, wr, addr, data);
        finish_access("access");
    endtask

    // read-data monitor
    always @(negedge clk) begin
        if (reset_n && bus.cpu_read && !bus.cpu_write && !bus.cpu_stall) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rdata_unexpected actual=%h required=no read completion", bus.cpu_rdata);
            end else begin
                check("rdata", bus.cpu_rdata, exp_q.pop_front());
            end
        end
    end

    // memblock model: accepts on negedge, 5-cycle read countdown, instant write
    always @(negedge clk) begin
        if (bus.blockwrite) begin
            check("wb_excl_read", bus.blockread, 1'b0);
            if (wbaddr_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL wb_unexpected actual=%h required=no write-back", bus.blockaddr);
            end else begin
                check("wb_addr", bus.blockaddr, wbaddr_q.pop_front());
                check("wb_data", bus.writeblock, wbdata_q.pop_front());
            end
            mem[bus.blockaddr[26:0]] = bus.writeblock;
        end
        if (!mb_ready) check("no_read_while_busy", bus.blockread, 1'b0);
        if (mb_ready && bus.blockread) begin
            if (rdaddr_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL refill_unexpected actual=%h required=no refill", bus.blockaddr);
            end else begin
                check("refill_addr", bus.blockaddr, rdaddr_q.pop_front());
            end
            mb_addr  = bus.blockaddr[26:0];
            mb_cnt   = 5;
            mb_ready = 1'b0;
        end else if (!mb_ready) begin
            mb_cnt--;
            if (mb_cnt == 0) begin
                mb_rdata = mem.exists(mb_addr) ? mem[mb_addr] : init_blk(mb_addr);
                mb_ready = 1'b1;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=still running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] addr;
        logic [63:0] data;
        int          op;
        bit          got;

        tags[0] = 24'h000000;
        tags[1] = 24'h000001;
        tags[2] = 24'h000002;
        tags[3] = 24'hABCDE1;
        set_idle();
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        model_reset();

        // clock/reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_stall", bus.cpu_stall, 1'b0);
        check("reset_blockread", bus.blockread, 1'b0);
        check("reset_blockwrite", bus.blockwrite, 1'b0);
        check("reset_hit_count", bus.hit_count, 32'd0);
        check("reset_miss_count", bus.miss_count, 32'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // first miss, then two zero-wait hits
        access(1'b1, 1'b0, 32'h0000_0000, 64'd0);
        check("first_miss_count", bus.miss_count, miss_exp);
        access(1'b1, 1'b0, 32'h0000_0000, 64'd0);
        access(1'b1, 1'b0, 32'h0000_0008, 64'd0);
        check("two_hits_count", bus.hit_count, hit_exp);

        // dirty victim write-back then refill of block 8; clean write miss
        access(1'b0, 1'b1, 32'h0000_0018, 64'hDEADBEEF_00000001);
        access(1'b1, 1'b0, 32'h0000_0118, 64'd0);
        access(1'b0, 1'b1, 32'h0000_0040, 64'h1234_5678_9ABC_DEF0);
        access(1'b1, 1'b0, 32'h0000_0040, 64'd0);
        access(1'b1, 1'b0, 32'h0000_0018, 64'd0);

        // reset while the refill is outstanding
        rdaddr_q.push_back(32'h0000_003F);
        issue(1'b1, 1'b0, 32'h0000_07E0, 64'd0);
        got = 1'b0;
        for (int n = 0; n < 50 && !got; n++) begin
            @(posedge clk);
            if (!mb_ready) got = 1'b1;
        end
        check("refill_started", got, 1'b1);
        #1;
        reset_n = 1'b0;
        set_idle();
        model_reset();
        #2;
        check("midreset_stall", bus.cpu_stall, 1'b0);
        check("midreset_miss_count", bus.miss_count, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        access(1'b1, 1'b0, 32'h0000_07E0, 64'd0);
        check("after_reset_miss", bus.miss_count, miss_exp);
        access(1'b1, 1'b0, 32'h0000_0018, 64'd0);

        // read and write together is a write
        access(1'b1, 1'b1, 32'h0000_0020, 64'hFEED_FACE_0BAD_F00D);
        access(1'b1, 1'b0, 32'h0000_0020, 64'd0);

        // randomized traffic with bubbles and dropped misses
        for (int i = 0; i < 400; i++) begin
            addr = {tags[$urandom_range(0, 3)], 3'($urandom_range(0, 7)),
                    2'($urandom_range(0, 3)), 3'b000};
            data = {$urandom, $urandom};
            op = $urandom_range(0, 99);
            if (op < 8 && !model_hit(addr)) begin
                model_access(1'b0, 1'b0, addr, data);
                issue(1'b1, 1'b0, addr, data);
                repeat (2) @(posedge clk);
                #1;
                set_idle();
                finish_access("drop");
            end else if (op < 50) begin
                access(1'b1, 1'b0, addr, data);
            end else if (op < 90) begin
                access(1'b0, 1'b1, addr, data);
            end else begin
                access(1'b1, 1'b1, addr, data);
            end
            if ($urandom_range(0, 9) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end

        repeat (20) @(posedge clk);
        @(negedge clk);
        check("final_hit_count", bus.hit_count, hit_exp);
        check("final_miss_count", bus.miss_count, miss_exp);
        check("final_stall", bus.cpu_stall, 1'b0);
        check("pending_reads", exp_q.size(), 0);
        check("pending_refills", rdaddr_q.size(), 0);
        check("pending_writebacks", wbaddr_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
